// File: rtl/canny_frame_ctrl.sv
// rtl/canny_frame_ctrl.sv - frame sequencer, flush injector and threshold owner for the canny pipeline
module canny_frame_ctrl #(
    parameter int DW           = 14,
    parameter int IH           = 512,
    parameter int IW           = 640,
    parameter int FLUSH_LEN    = 1344,
    parameter int DRAIN_TMO    = 4096,
    parameter int THR_HIGH_RST = 20,
    parameter int THR_LOW_RST  = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enable,
    input  logic          cfg_wr,
    input  logic [DW-1:0] cfg_thr_high,
    input  logic [DW-1:0] cfg_thr_low,
    input  logic          src_valid,
    input  logic [DW-1:0] src_data,
    input  logic          src_vsync,
    output logic          pipe_valid,
    output logic [DW-1:0] pipe_data,
    output logic          pipe_vsync,
    output logic [DW-1:0] thr_high,
    output logic [DW-1:0] thr_low,
    input  logic          res_valid,
    output logic          res_keep,
    output logic          busy,
    output logic          frame_done,
    output logic          err_short,
    output logic          err_long,
    output logic          err_tmo
);

    localparam int NPIX = IH * IW;
    localparam int COLW = $clog2(IW > 1 ? IW : 2);
    localparam int ROWW = $clog2(IH > 1 ? IH : 2);
    localparam int RCW  = $clog2(NPIX + 1);
    localparam int PMAX = (FLUSH_LEN > DRAIN_TMO) ? FLUSH_LEN : DRAIN_TMO;
    localparam int PW   = $clog2(PMAX + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_VS, S_RUN, S_FLUSH, S_DRAIN, S_DONE
    } state_t;

    state_t state, state_nx;

    logic            vs_q, vs_rise;
    logic            last_pix, restart, frame_start;
    logic            flush_end, drain_full, drain_tmo, run_pix;
    logic [COLW-1:0] col, col_base;
    logic [ROWW-1:0] row, row_base;
    logic [RCW-1:0]  res_cnt;
    logic [PW-1:0]   ph_cnt;
    logic [DW-1:0]   shadow_high, shadow_low;

    assign vs_rise     = src_vsync & ~vs_q;
    assign run_pix     = (state == S_RUN) && src_valid;
    // The final pixel beats a coincident vsync edge: the frame completes and the edge is dropped.
    assign last_pix    = run_pix && (row == ROWW'(IH - 1)) && (col == COLW'(IW - 1));
    assign restart     = (state == S_RUN) && vs_rise && !last_pix;
    assign frame_start = ((state == S_WAIT_VS) && vs_rise) || restart;
    assign flush_end   = (state == S_FLUSH) && (ph_cnt == PW'(FLUSH_LEN - 1));
    assign drain_full  = (res_cnt == RCW'(NPIX));
    assign drain_tmo   = (state == S_DRAIN) && !drain_full && (ph_cnt == PW'(DRAIN_TMO - 1));
    assign col_base    = frame_start ? '0 : col;
    assign row_base    = frame_start ? '0 : row;
    assign res_keep    = res_valid & busy & (res_cnt < RCW'(NPIX));

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:    if (enable) state_nx = S_WAIT_VS;
            S_WAIT_VS: begin
                if (vs_rise)      state_nx = S_RUN;
                else if (!enable) state_nx = S_IDLE;
            end
            S_RUN:     if (last_pix) state_nx = S_FLUSH;
            S_FLUSH:   if (flush_end) state_nx = S_DRAIN;
            S_DRAIN:   if (drain_full || drain_tmo) state_nx = S_DONE;
            S_DONE:    state_nx = enable ? S_WAIT_VS : S_IDLE;
            default:   state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            vs_q   <= 1'b0;
            ph_cnt <= '0;
        end else begin
            state <= state_nx;
            vs_q  <= src_vsync;
            if (state_nx != state || !(state == S_FLUSH || state == S_DRAIN))
                ph_cnt <= '0;
            else
                ph_cnt <= ph_cnt + PW'(1);
        end
    end

    // A pixel on a restart cycle is pixel 0 of the new frame, hence the zeroed base.
    always_ff @(posedge clk) begin
        if (rst) begin
            col     <= '0;
            row     <= '0;
            res_cnt <= '0;
        end else begin
            if (run_pix) begin
                if (col_base == COLW'(IW - 1)) begin
                    col <= '0;
                    row <= row_base + ROWW'(1);
                end else begin
                    col <= col_base + COLW'(1);
                    row <= row_base;
                end
            end else if (frame_start) begin
                col <= '0;
                row <= '0;
            end
            if (frame_start)
                res_cnt <= '0;
            else if (res_keep)
                res_cnt <= res_cnt + RCW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_high <= DW'(THR_HIGH_RST);
            shadow_low  <= DW'(THR_LOW_RST);
            thr_high    <= DW'(THR_HIGH_RST);
            thr_low     <= DW'(THR_LOW_RST);
        end else begin
            if (cfg_wr) begin
                shadow_high <= cfg_thr_high;
                shadow_low  <= cfg_thr_low;
            end
            if (frame_start) begin
                thr_high <= cfg_wr ? cfg_thr_high : shadow_high;
                thr_low  <= cfg_wr ? cfg_thr_low  : shadow_low;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_valid <= 1'b0;
            pipe_data  <= '0;
            pipe_vsync <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            err_short  <= 1'b0;
            err_long   <= 1'b0;
            err_tmo    <= 1'b0;
        end else begin
            pipe_valid <= run_pix || (state == S_FLUSH);
            pipe_data  <= run_pix ? src_data : '0;
            pipe_vsync <= frame_start;
            busy       <= (state_nx == S_RUN) || (state_nx == S_FLUSH) || (state_nx == S_DRAIN);
            frame_done <= (state_nx == S_DONE);
            err_short  <= restart;
            err_long   <= src_valid && (state == S_FLUSH || state == S_DRAIN);
            err_tmo    <= drain_tmo;
        end
    end

endmodule

// File: tb/tb_canny_frame_ctrl.sv
// tb/tb_canny_frame_ctrl.sv - randomized bench with a frame-level reference model for canny_frame_ctrl
module tb_canny_frame_ctrl;

    localparam int DW   = 14;
    localparam int IH   = 4;
    localparam int IW   = 8;
    localparam int NPIX = IH * IW;
    localparam int FL   = 20;
    localparam int TMO  = 50;

    localparam int M_IDLE = 0, M_WAIT = 1, M_RUN = 2, M_FLUSH = 3, M_DRAIN = 4, M_DONE = 5;

    logic          clk = 1'b0;
    logic          rst, enable, cfg_wr, src_valid, src_vsync, res_valid;
    logic [DW-1:0] cfg_thr_high, cfg_thr_low, src_data;
    logic          pipe_valid, pipe_vsync, res_keep, busy, frame_done;
    logic          err_short, err_long, err_tmo;
    logic [DW-1:0] pipe_data, thr_high, thr_low;

    always #5 clk = ~clk;

    canny_frame_ctrl #(
        .DW(DW), .IH(IH), .IW(IW), .FLUSH_LEN(FL), .DRAIN_TMO(TMO),
        .THR_HIGH_RST(20), .THR_LOW_RST(10)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .cfg_wr(cfg_wr),
        .cfg_thr_high(cfg_thr_high), .cfg_thr_low(cfg_thr_low),
        .src_valid(src_valid), .src_data(src_data), .src_vsync(src_vsync),
        .pipe_valid(pipe_valid), .pipe_data(pipe_data), .pipe_vsync(pipe_vsync),
        .thr_high(thr_high), .thr_low(thr_low), .res_valid(res_valid),
        .res_keep(res_keep), .busy(busy), .frame_done(frame_done),
        .err_short(err_short), .err_long(err_long), .err_tmo(err_tmo)
    );

    int n_tests = 0, n_fail = 0;

    // reference model: frame progress as plain pixel / cycle / result counts
    int            m_mode = M_IDLE, m_pix = 0, m_ph = 0, m_res = 0;
    logic          m_vsq = 1'b0;
    logic [DW-1:0] m_sh = 20, m_sl = 10, m_ah = 20, m_al = 10;
    logic          e_pv = 0, e_pvs = 0, e_busy = 0, e_done = 0, e_es = 0, e_el = 0, e_et = 0;
    logic [DW-1:0] e_pd = 0;
    bit            model_ok = 0;

    logic          res_en;
    logic [31:0]   hist;

    int cyc = 0, last_pv = 0, done_gap = -1;
    int cnt_done, cnt_keep, cnt_flush0, cnt_res, cnt_pv, cnt_pvs, cnt_short, cnt_long, cnt_tmo, cnt_tmo_done;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        logic rise, start, busy_old;
        int   nm, res_old;
        if (rst) begin
            m_mode = M_IDLE; m_pix = 0; m_ph = 0; m_res = 0; m_vsq = 0;
            m_sh = 20; m_sl = 10; m_ah = 20; m_al = 10;
            e_pv = 0; e_pd = 0; e_pvs = 0; e_busy = 0; e_done = 0; e_es = 0; e_el = 0; e_et = 0;
            model_ok = 1;
        end else begin
            rise = src_vsync && !m_vsq;
            m_vsq = src_vsync;
            e_pv = 0; e_pd = 0; e_es = 0; e_el = 0; e_et = 0;
            start = 0;
            nm = m_mode;
            busy_old = (m_mode == M_RUN || m_mode == M_FLUSH || m_mode == M_DRAIN);
            res_old = m_res;
            case (m_mode)
                M_IDLE: if (enable) nm = M_WAIT;
                M_WAIT: begin
                    if (rise) begin start = 1; m_pix = 0; nm = M_RUN; end
                    else if (!enable) nm = M_IDLE;
                end
                M_RUN: begin
                    if (rise && !(src_valid && m_pix == NPIX - 1)) begin
                        start = 1; e_es = 1; m_pix = 0;
                    end
                    if (src_valid) begin e_pv = 1; e_pd = src_data; m_pix++; end
                    if (m_pix == NPIX) nm = M_FLUSH;
                end
                M_FLUSH: begin
                    e_pv = 1;
                    if (src_valid) e_el = 1;
                    m_ph++;
                    if (m_ph == FL) nm = M_DRAIN;
                end
                M_DRAIN: begin
                    if (src_valid) e_el = 1;
                    if (res_old == NPIX) nm = M_DONE;
                    else begin
                        m_ph++;
                        if (m_ph == TMO) begin nm = M_DONE; e_et = 1; end
                    end
                end
                default: nm = enable ? M_WAIT : M_IDLE;
            endcase
            if (nm != m_mode) m_ph = 0;
            if (busy_old && res_valid && m_res < NPIX) m_res++;
            if (start) begin
                m_res = 0;
                m_ah = cfg_wr ? cfg_thr_high : m_sh;
                m_al = cfg_wr ? cfg_thr_low : m_sl;
            end
            if (cfg_wr) begin m_sh = cfg_thr_high; m_sl = cfg_thr_low; end
            e_pvs = start;
            m_mode = nm;
            e_busy = (nm == M_RUN || nm == M_FLUSH || nm == M_DRAIN);
            e_done = (nm == M_DONE);
        end
    endtask

    // advance one clock; the result stream is pipe_valid seen through a fixed-delay pipeline
    task automatic tick();
        @(posedge clk);
        model_step();
        #2;
        hist = {hist[30:0], pipe_valid};
        res_valid = res_en && hist[24];
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic pix(input int n);
        for (int i = 0; i < n; i++) begin
            idle($urandom_range(0, 2));
            src_valid = 1;
            src_data = DW'($urandom_range(1, (1 << DW) - 1));
            tick();
            src_valid = 0;
            src_data = 0;
        end
    endtask

    task automatic vs_edge(input bit with_pix);
        src_vsync = 1;
        src_valid = with_pix;
        src_data = DW'($urandom_range(1, 100));
        tick();
        src_vsync = 0;
        src_valid = 0;
        src_data = 0;
    endtask

    task automatic wait_done(input string name);
        bit seen = 0;
        for (int i = 0; i < 600 && !seen; i++) begin
            tick();
            if (frame_done) seen = 1;
        end
        check(name, seen, 1);
    endtask

    task automatic clear_counts();
        cnt_done = 0; cnt_keep = 0; cnt_flush0 = 0; cnt_res = 0; cnt_pv = 0; cnt_pvs = 0;
        cnt_short = 0; cnt_long = 0; cnt_tmo = 0; cnt_tmo_done = 0; done_gap = -1;
    endtask

    initial forever begin
        @(negedge clk);
        cyc++;
        if (model_ok) begin
            check("pipe_valid", pipe_valid, e_pv);
            check("pipe_data", pipe_data, e_pd);
            check("pipe_vsync", pipe_vsync, e_pvs);
            check("thr_high", thr_high, m_ah);
            check("thr_low", thr_low, m_al);
            check("busy", busy, e_busy);
            check("frame_done", frame_done, e_done);
            check("err_short", err_short, e_es);
            check("err_long", err_long, e_el);
            check("err_tmo", err_tmo, e_et);
            check("res_keep", res_keep, res_valid && e_busy && (m_res < NPIX));
        end
        if (pipe_valid) begin last_pv = cyc; cnt_pv++; end
        if (pipe_valid && pipe_data == 0) cnt_flush0++;
        if (frame_done) begin cnt_done++; done_gap = cyc - last_pv; end
        if (res_keep) cnt_keep++;
        if (res_valid) cnt_res++;
        if (pipe_vsync) cnt_pvs++;
        if (err_short) cnt_short++;
        if (err_long) cnt_long++;
        if (err_tmo) cnt_tmo++;
        if (err_tmo && frame_done) cnt_tmo_done++;
    end

    initial begin
        rst = 1; enable = 0; cfg_wr = 0; cfg_thr_high = 0; cfg_thr_low = 0;
        src_valid = 0; src_data = 0; src_vsync = 0; res_valid = 0; res_en = 1; hist = 0;
        clear_counts();
        idle(3);
        check("rst_thr_high", thr_high, 20);
        check("rst_thr_low", thr_low, 10);
        check("rst_busy", busy, 0);
        rst = 0; enable = 1;
        idle(2);

        // normal frame, shadow write mid-frame must not reach the active thresholds
        clear_counts();
        vs_edge(1);
        pix(10);
        cfg_wr = 1; cfg_thr_high = 30; cfg_thr_low = 15;
        tick();
        cfg_wr = 0;
        check("mid_thr_high", thr_high, 20);
        check("mid_thr_low", thr_low, 10);
        pix(22);
        wait_done("f1_done_seen");
        idle(40);
        check("f1_done_cnt", cnt_done, 1);
        check("f1_keep_cnt", cnt_keep, 32);
        check("f1_flush_cnt", cnt_flush0, 20);
        check("f1_res_cnt", cnt_res, 52);
        check("f1_pv_cnt", cnt_pv, 52);

        // shadows apply at the next frame start
        clear_counts();
        vs_edge(0);
        check("f2_thr_high", thr_high, 30);
        check("f2_thr_low", thr_low, 15);
        pix(32);
        wait_done("f2_done_seen");
        idle(40);

        // write coinciding with the frame start goes straight to the active registers
        cfg_wr = 1; cfg_thr_high = 40; cfg_thr_low = 5; src_vsync = 1;
        tick();
        cfg_wr = 0; src_vsync = 0;
        check("f3_thr_high", thr_high, 40);
        check("f3_thr_low", thr_low, 5);
        pix(32);
        wait_done("f3_done_seen");
        idle(40);

        // short frame: restart after 17 pixels, restart pixel becomes pixel 0
        clear_counts();
        vs_edge(0);
        pix(17);
        src_vsync = 1; src_valid = 1; src_data = DW'($urandom_range(1, 500));
        tick();
        src_vsync = 0; src_valid = 0; src_data = 0;
        pix(31);
        wait_done("short_done_seen");
        idle(40);
        check("short_err_cnt", cnt_short, 1);
        check("short_pvs_cnt", cnt_pvs, 2);
        check("short_done_cnt", cnt_done, 1);

        // long frame: extra pixel during flush
        clear_counts();
        vs_edge(0);
        pix(32);
        idle(3);
        src_valid = 1; src_data = DW'(77);
        tick();
        src_valid = 0; src_data = 0;
        wait_done("long_done_seen");
        idle(40);
        check("long_err_cnt", cnt_long, 1);
        check("long_flush_cnt", cnt_flush0, 20);
        check("long_done_cnt", cnt_done, 1);

        // drain timeout with no results
        clear_counts();
        res_en = 0;
        vs_edge(0);
        pix(32);
        wait_done("tmo_done_seen");
        idle(2);
        check("tmo_err_cnt", cnt_tmo, 1);
        check("tmo_with_done", cnt_tmo_done, 1);
        check("tmo_gap", done_gap, 50);
        res_en = 1;
        idle(40);

        // reset mid-frame
        clear_counts();
        vs_edge(0);
        cfg_wr = 1; cfg_thr_high = 33; cfg_thr_low = 3;
        tick();
        cfg_wr = 0;
        pix(10);
        rst = 1;
        tick();
        rst = 0;
        check("rrst_pipe_valid", pipe_valid, 0);
        check("rrst_busy", busy, 0);
        check("rrst_thr_high", thr_high, 20);
        check("rrst_thr_low", thr_low, 10);
        idle(30);
        clear_counts();
        pix(8);
        idle(2);
        check("rrst_no_fwd", cnt_pv, 0);
        check("rrst_no_done", cnt_done, 0);
        vs_edge(0);
        pix(32);
        wait_done("rrst_done_seen");
        idle(40);

        // random frames with random shadow writes
        for (int f = 0; f < 4; f++) begin
            cfg_wr = 1;
            cfg_thr_high = DW'($urandom_range(0, (1 << DW) - 1));
            cfg_thr_low = DW'($urandom_range(0, (1 << DW) - 1));
            tick();
            cfg_wr = 0;
            vs_edge($urandom_range(0, 1));
            pix(32);
            wait_done("rand_done_seen");
            idle(40);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
